cpu_run_ctrl: RTL and testbench

Parametrised run controller that sequences a MIPS core through its reset / run / stop phases.
- Holds the core in reset for a programmable number of cycles.
- Counts cycles and retired instructions while the core runs.
- Detects program end as a jump-to-self: the same retired PC repeated N times.
- Aborts with a timeout flag after a cycle budget is exhausted.
- Sits between the top-level clk/reset and the core's reset input. It replaces fixed-delay reset/run sequencing with a deterministic, countable one.

---
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: reset/run/halt/timeout sequencer for a MIPS core.
// Optional macro RUN_CTRL_STALL_EN adds a stall input and a stall_count output.
`default_nettype none

module cpu_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 5,
  parameter int MAX_CYCLES  = 500,
  parameter int HALT_REPEAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
`ifdef RUN_CTRL_STALL_EN
  input  logic             stall,
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [PC_W-1:0]  final_pc
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);

  typedef enum logic [1:0] {
    S_RST     = 2'd0,
    S_RUN     = 2'd1,
    S_HALT    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [PC_W-1:0]   final_q, final_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              count_en;
  logic              halt_hit;
  logic [REP_W-1:0]  rep_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      final_q   <= '0;
      last_pc_q <= '0;
      rep_q     <= '0;
      first_q   <= 1'b1;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      final_q   <= final_d;
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
      first_q   <= first_d;
      stall_q   <= stall_d;
    end
  end

  // Stalled cycles do not consume the cycle budget.
`ifdef RUN_CTRL_STALL_EN
  assign count_en = ~stall;
`else
  assign count_en = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    final_d   = final_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    first_d   = first_q;
    stall_d   = stall_q;
    halt_hit  = 1'b0;
    rep_next  = rep_q;

    case (state_q)
      S_RST: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (count_en) begin
          cycle_d = cycle_q + CNT_W'(1);
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
        if (pc_valid) begin
          retire_d = retire_q + CNT_W'(1);
          first_d  = 1'b0;
          // The first retirement always reloads, so a first PC of 0 is not a repeat.
          if (!first_q && (pc == last_pc_q)) begin
            rep_next = rep_q + REP_W'(1);
          end else begin
            rep_next  = REP_W'(1);
            last_pc_d = pc;
          end
          rep_d    = rep_next;
          halt_hit = (rep_next == REP_HALT);
        end
        if (halt_hit) begin
          state_d = S_HALT;
          final_d = pc;
        end else if (count_en && (cycle_q == CYC_LAST)) begin
          state_d = S_TIMEOUT;
          final_d = last_pc_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign cpu_reset    = (state_q == S_RST);
  assign running      = (state_q == S_RUN);
  assign done         = (state_q == S_HALT);
  assign timeout      = (state_q == S_TIMEOUT);
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign final_pc     = final_q;
`ifdef RUN_CTRL_STALL_EN
  assign stall_count  = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (MAX_CYCLES=20, HALT_REPEAT=4, RST_CYCLES=5).
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int PC_W = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             cpu_reset, running, done, timeout;
  logic [CNT_W-1:0] cycle_count, retire_count;
  logic [PC_W-1:0]  final_pc;
`ifdef RUN_CTRL_STALL_EN
  logic             stall;
  logic [CNT_W-1:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(5), .MAX_CYCLES(20), .HALT_REPEAT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .pc_valid(pc_valid),
`ifdef RUN_CTRL_STALL_EN
    .stall(stall),
    .stall_count(stall_count),
`endif
    .cpu_reset(cpu_reset),
    .running(running),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .retire_count(retire_count),
    .final_pc(final_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then five cpu_reset cycles: returns with the DUT just entered RUN.
  task automatic go_run();
    reset = 1'b1; pc_valid = 1'b0; pc = '0;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_valid = 1'b0; pc = '0;
`ifdef RUN_CTRL_STALL_EN
    stall = 1'b0;
`endif
    repeat (3) step();
    checks++; if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got rst=%b run=%b done=%b to=%b expected 1 0 0 0", cpu_reset, running, done, timeout);
    end
    checks++; if (cycle_count !== 32'd0 || retire_count !== 32'd0 || final_pc !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got cyc=%0d ret=%0d fpc=%h expected 0 0 0", cycle_count, retire_count, final_pc);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cpu_reset !== 1'b1 || running !== 1'b0) begin
        errors++; $display("FAIL reset_hold_%0d: got rst=%b run=%b expected 1 0", i, cpu_reset, running);
      end
      step();
    end
    checks++; if (cpu_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_release: got rst=%b run=%b cyc=%0d expected 0 1 0", cpu_reset, running, cycle_count);
    end
  endtask

  task automatic test_halt();
    logic [31:0] pcs [7];
    pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h300c, 32'h300c, 32'h300c};
    go_run();
    for (int i = 0; i < 7; i++) begin
      checks++; if (done !== 1'b0) begin
        errors++; $display("FAIL halt_early_%0d: got done=%b expected 0", i, done);
      end
      pc = pcs[i]; pc_valid = 1'b1;
      step();
    end
    checks++; if (done !== 1'b1 || timeout !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL halt_flags: got done=%b to=%b run=%b expected 1 0 0", done, timeout, running);
    end
    checks++; if (final_pc !== 32'h300c || retire_count !== 32'd7 || cycle_count !== 32'd7) begin
      errors++; $display("FAIL halt_values: got fpc=%h ret=%0d cyc=%0d expected 300c 7 7", final_pc, retire_count, cycle_count);
    end
    pc = 32'h9999; pc_valid = 1'b1;
    repeat (3) step();
    checks++; if (done !== 1'b1 || final_pc !== 32'h300c || retire_count !== 32'd7 || cycle_count !== 32'd7) begin
      errors++; $display("FAIL halt_frozen: got done=%b fpc=%h ret=%0d cyc=%0d expected 1 300c 7 7", done, final_pc, retire_count, cycle_count);
    end
    pc_valid = 1'b0;
  endtask

  task automatic test_timeout();
    go_run();
    for (int i = 1; i <= 20; i++) begin
      pc = 32'h1000 + 32'((i - 1) * 4);
      pc_valid = (i <= 19);
      step();
      if (i == 19) begin
        checks++; if (running !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd19) begin
          errors++; $display("FAIL timeout_early: got run=%b to=%b cyc=%0d expected 1 0 19", running, timeout, cycle_count);
        end
      end
    end
    checks++; if (timeout !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd20) begin
      errors++; $display("FAIL timeout_flags: got to=%b done=%b cyc=%0d expected 1 0 20", timeout, done, cycle_count);
    end
    checks++; if (final_pc !== 32'h1048 || retire_count !== 32'd19) begin
      errors++; $display("FAIL timeout_values: got fpc=%h ret=%0d expected 1048 19", final_pc, retire_count);
    end
    pc_valid = 1'b1; pc = 32'h5555;
    step(); step();
    checks++; if (timeout !== 1'b1 || cycle_count !== 32'd20 || retire_count !== 32'd19) begin
      errors++; $display("FAIL timeout_frozen: got to=%b cyc=%0d ret=%0d expected 1 20 19", timeout, cycle_count, retire_count);
    end
    pc_valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    go_run();
    for (int i = 1; i <= 20; i++) begin
      pc = (i <= 16) ? 32'h2000 + 32'(i * 4) : 32'h3010;
      pc_valid = 1'b1;
      step();
    end
    checks++; if (done !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL simul_flags: got done=%b to=%b expected 1 0", done, timeout);
    end
    checks++; if (final_pc !== 32'h3010 || cycle_count !== 32'd20 || retire_count !== 32'd20) begin
      errors++; $display("FAIL simul_values: got fpc=%h cyc=%0d ret=%0d expected 3010 20 20", final_pc, cycle_count, retire_count);
    end
    pc_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    go_run();
    for (int i = 1; i <= 7; i++) begin
      pc = (i <= 5) ? 32'h4000 + 32'(i * 4) : 32'h5000;
      pc_valid = 1'b1;
      step();
    end
    reset = 1'b1; pc_valid = 1'b0;
    step();
    checks++; if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== 32'd0 || retire_count !== 32'd0 || final_pc !== 32'd0) begin
      errors++; $display("FAIL midrun_reset: got rst=%b run=%b cyc=%0d ret=%0d fpc=%h expected 1 0 0 0 0", cpu_reset, running, cycle_count, retire_count, final_pc);
    end
    reset = 1'b0;
    repeat (5) step();
    pc = 32'h5000; pc_valid = 1'b1;
    repeat (3) step();
    checks++; if (done !== 1'b0 || running !== 1'b1 || retire_count !== 32'd3) begin
      errors++; $display("FAIL midrun_three: got done=%b run=%b ret=%0d expected 0 1 3", done, running, retire_count);
    end
    step();
    checks++; if (done !== 1'b1 || final_pc !== 32'h5000 || retire_count !== 32'd4) begin
      errors++; $display("FAIL midrun_halt: got done=%b fpc=%h ret=%0d expected 1 5000 4", done, final_pc, retire_count);
    end
    pc_valid = 1'b0;
  endtask

`ifdef RUN_CTRL_STALL_EN
  task automatic test_stall();
    go_run();
    checks++; if (stall_count !== 32'd0) begin
      errors++; $display("FAIL stall_reset: got %0d expected 0", stall_count);
    end
    // Stall on RUN cycles 2,4,6,8,10; retire a fresh PC every cycle.
    for (int i = 1; i <= 12; i++) begin
      stall = (i % 2 == 0) && (i <= 10);
      pc = 32'h6000 + 32'(i * 4); pc_valid = 1'b1;
      step();
    end
    stall = 1'b0;
    checks++; if (cycle_count !== 32'd7 || stall_count !== 32'd5 || retire_count !== 32'd12 || timeout !== 1'b0) begin
      errors++; $display("FAIL stall_mid: got cyc=%0d stl=%0d ret=%0d to=%b expected 7 5 12 0", cycle_count, stall_count, retire_count, timeout);
    end
    pc_valid = 1'b0;
    repeat (12) step();
    checks++; if (timeout !== 1'b0 || cycle_count !== 32'd19) begin
      errors++; $display("FAIL stall_before_to: got to=%b cyc=%0d expected 0 19", timeout, cycle_count);
    end
    stall = 1'b1;
    step();
    checks++; if (timeout !== 1'b0 || stall_count !== 32'd6) begin
      errors++; $display("FAIL stall_no_budget: got to=%b stl=%0d expected 0 6", timeout, stall_count);
    end
    stall = 1'b0;
    step();
    checks++; if (timeout !== 1'b1 || cycle_count !== 32'd20 || stall_count !== 32'd6) begin
      errors++; $display("FAIL stall_timeout: got to=%b cyc=%0d stl=%0d expected 1 20 6", timeout, cycle_count, stall_count);
    end
    stall = 1'b1;
    step();
    checks++; if (stall_count !== 32'd6) begin
      errors++; $display("FAIL stall_frozen: got %0d expected 6", stall_count);
    end
    stall = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; pc = '0; pc_valid = 1'b0;
`ifdef RUN_CTRL_STALL_EN
    stall = 1'b0;
`endif
    test_reset();
    test_halt();
    test_timeout();
    test_simultaneous();
    test_reset_mid_run();
`ifdef RUN_CTRL_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
